kanagawa_hal_auto_pipeline_receiver: RTL and testbench



---
 rtl/kanagawa_hal_auto_pipeline_receiver.sv | 73 +++++++
 tb/tb_kanagawa_hal_auto_pipeline_receiver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/kanagawa_hal_auto_pipeline_receiver.sv
// Receive-end FIFO for a non-stallable enable/data chain; re-presents beats on ready/valid.
// Latency: 1 cycle write-to-output; backpressure via registered almost_full, drops flagged by sticky overflow.
module kanagawa_hal_auto_pipeline_receiver #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int SKID  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       valid_out,
    output logic [WIDTH-1:0]           data_out,
    input  logic                       ready_in,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - SKID);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic             pop;
    logic             push;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_next;

    always_comb begin
        pop         = valid_out & ready_in;
        push        = enable_in & ((count < FULL_LVL) | pop);
        count_next  = count + CW'(push) - CW'(pop);
        rd_ptr_next = rd_ptr + AW'(pop);
        // The new head is the beat being written this edge only when it lands on the next read slot
        if (push && (wr_ptr == rd_ptr_next))
            head_next = data_in;
        else
            head_next = mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            valid_out   <= (count_next != '0);
            almost_full <= (count_next >= AF_LVL);
            if (enable_in && !push)
                overflow <= 1'b1;
            // Hold data_out when going empty so stale or unwritten storage never reaches the output
            if (count_next != '0)
                data_out <= head_next;
        end
    end
endmodule

// File: tb/tb_kanagawa_hal_auto_pipeline_receiver.sv
// Bench for kanagawa_hal_auto_pipeline_receiver: vector table plus queue scoreboard and directed corner cases.
module tb_kanagawa_hal_auto_pipeline_receiver;
    localparam int W = 32;
    localparam int D = 16;
    localparam int S = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable_in = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready_in = 1'b0;
    logic         valid_out;
    logic [W-1:0] data_out;
    logic         almost_full;
    logic [$clog2(D):0] count;
    logic         overflow;

    kanagawa_hal_auto_pipeline_receiver #(.WIDTH(W), .DEPTH(D), .SKID(S)) dut (
        .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .data_in(data_in),
        .valid_out(valid_out), .data_out(data_out), .ready_in(ready_in),
        .almost_full(almost_full), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q[$];
    int m_count = 0;
    bit m_ovf = 1'b0;

    typedef struct {
        logic        en;
        logic [31:0] dat;
        logic        rdy;
        int          exp_cnt;
        logic        exp_vld;
        logic        exp_af;
        logic [31:0] exp_dat;
    } vec_t;
    vec_t tbl[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void add(logic en, logic [31:0] dat, logic rdy, int c, logic v, logic af, logic [31:0] dd);
        vec_t r;
        r.en = en; r.dat = dat; r.rdy = rdy; r.exp_cnt = c; r.exp_vld = v; r.exp_af = af; r.exp_dat = dd;
        tbl.push_back(r);
    endfunction

    // Called at a falling edge; drives one cycle, scores any pop, and returns at the next falling edge.
    task automatic step(input logic en, input logic [W-1:0] d, input logic rdy);
        bit mpop, mpush;
        enable_in = en;
        data_in   = en ? d : 'x;
        ready_in  = rdy;
        mpop = (m_count != 0) && rdy;
        if (mpop) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_empty_scoreboard actual=%0h required=none", data_out);
            end else begin
                chk("pop_data", data_out, q.pop_front());
            end
        end
        mpush = en && ((m_count < D) || mpop);
        if (mpush) q.push_back(d);
        if (en && !mpush) m_ovf = 1'b1;
        m_count = m_count + int'(mpush) - int'(mpop);
        @(posedge clk);
        @(negedge clk);
        chk("count", 32'(count), 32'(m_count));
        chk("valid", 32'(valid_out), 32'(m_count != 0));
    endtask

    task automatic mid_reset();
        enable_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        q.delete();
        m_count = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (m_count != 0 && n < max_cyc) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        if (m_count != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d required=0", m_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  afd;
        int          issued;
        int          cyc;
        bit          did_rst;
        logic        en;
        logic [31:0] d;

        // Reset idle, single beat, threshold rise/fall, then drain
        for (int i = 0; i < 10; i++) add(1'b0, 0, 1'b1, 0, 1'b0, 1'b0, 0);
        add(1'b1, 32'hDEADBEEF, 1'b1, 1, 1'b1, 1'b0, 32'hDEADBEEF);
        add(1'b0, 0, 1'b1, 0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) add(1'b1, i, 1'b0, i + 1, 1'b1, (i + 1) >= (D - S), 0);
        add(1'b0, 0, 1'b1, 7, 1'b1, 1'b0, 1);
        for (int i = 0; i < 7; i++) add(1'b0, 0, 1'b1, 6 - i, (6 - i) != 0, 1'b0, i + 2);

        #2;
        chk("reset_count", 32'(count), 0);
        chk("reset_valid", 32'(valid_out), 0);
        chk("reset_af", 32'(almost_full), 0);
        chk("reset_ovf", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].dat, tbl[i].rdy);
            chk("tbl_count", 32'(count), 32'(tbl[i].exp_cnt));
            chk("tbl_valid", 32'(valid_out), 32'(tbl[i].exp_vld));
            chk("tbl_af", 32'(almost_full), 32'(tbl[i].exp_af));
            chk("tbl_ovf", 32'(overflow), 0);
            if (tbl[i].exp_vld) chk("tbl_data", data_out, tbl[i].exp_dat);
        end

        // Overflow: the 17th beat is dropped and never reappears
        for (int i = 0; i <= 16; i++) step(1'b1, i, 1'b0);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_af", 32'(almost_full), 1);
        drain(40);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_empty", 32'(valid_out), 0);
        mid_reset();

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) step(1'b1, 32'h200 + i, 1'b0);
        step(1'b1, 32'h100, 1'b1);
        chk("full_pp_count", 32'(count), 16);
        chk("full_pp_ovf", 32'(overflow), 0);
        drain(40);
        chk("full_pp_q_empty", 32'(q.size()), 0);

        // Push+pop at count=1: new beat becomes head
        step(1'b1, 32'hA1, 1'b0);
        step(1'b1, 32'hA2, 1'b1);
        chk("one_pp_count", 32'(count), 1);
        chk("one_pp_head", data_out, 32'hA2);
        drain(10);

        // Random traffic; sender reacts to almost_full four cycles late
        afd = '0; issued = 0; cyc = 0; did_rst = 1'b0;
        while (issued < 1000 && cyc < 30000) begin
            en = !afd[3] && ($urandom_range(0, 1) == 1);
            d  = $urandom;
            step(en, d, $urandom_range(0, 1) == 1);
            if (en) issued++;
            cyc++;
            afd = {afd[2:0], almost_full};
            if (issued == 500 && !did_rst) begin
                did_rst = 1'b1;
                mid_reset();
                afd = '0;
            end
        end
        if (issued < 1000) begin
            checks++; errors++;
            $display("FAIL random_timeout actual=%0d required=1000", issued);
        end
        drain(100);
        chk("rand_ovf", 32'(overflow), 32'(m_ovf));
        chk("rand_ovf_zero", 32'(overflow), 0);
        chk("rand_q_empty", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
